// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-controller FSM states, register-address width
// and the NOP instruction that IF/ID loads on a flush.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StStart,
        StRun,
        StMemWait
    } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard controller bus.
//   master: pipeline side, drives ID/EX/MEM status and observes the stall/flush controls.
//   slave : hazard_control_unit, consumes status and produces controls and counters.
interface hazard_control_unit_if #(
    parameter int unsigned COUNT_W = 32
);
    import pipeline_pkg::*;

    logic [REG_ADDR_W-1:0] rs1_if_id;
    logic [REG_ADDR_W-1:0] rs2_if_id;
    logic                  uses_rs1_id;
    logic                  uses_rs2_id;
    logic [REG_ADDR_W-1:0] rd_id_ex;
    logic                  mem_read_id_ex;
    logic                  branch_taken_ex;
    logic                  dmem_req;
    logic                  dmem_ready;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  pipe_hold;
    logic                  mem_timeout;
    logic [COUNT_W-1:0]    stall_count;
    logic [COUNT_W-1:0]    flush_count;

    modport master (
        output rs1_if_id, rs2_if_id, uses_rs1_id, uses_rs2_id, rd_id_ex, mem_read_id_ex,
        output branch_taken_ex, dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout,
        input  stall_count, flush_count
    );

    modport slave (
        input  rs1_if_id, rs2_if_id, uses_rs1_id, uses_rs2_id, rd_id_ex, mem_read_id_ex,
        input  branch_taken_ex, dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout,
        output stall_count, flush_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one unless already all-ones
//   clr        : load zero
//   count      : current value
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Central stall/flush controller beside ID: load-use interlock, taken-branch flush from EX,
// data-memory wait freeze and the one-cycle post-reset purge. Keeps saturating stall/flush
// counters and a sticky memory-timeout flag.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   hcu        : slave side of hazard_control_unit_if (status in, controls/counters out)
// Control outputs are combinational from inputs and current state.
module hazard_control_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned COUNT_W        = 32,
    parameter int unsigned WAIT_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_control_unit_if.slave  hcu
);

    hcu_state_e state_q, state_d;

    logic freeze;
    logic load_use;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;
    logic stall_inc, flush_inc;
    logic wait_clr, wait_inc;
    logic [WAIT_W-1:0] wait_cnt;
    logic mem_timeout_q, mem_timeout_d;
    logic [COUNT_W-1:0] stall_count, flush_count;

    // A miss in RUN freezes immediately; in MEM_WAIT the freeze holds until ready,
    // regardless of dmem_req.
    assign freeze = ((state_q == StRun) && hcu.dmem_req && !hcu.dmem_ready) ||
                    ((state_q == StMemWait) && !hcu.dmem_ready);

    // x0 is never a real dependency.
    assign load_use = hcu.mem_read_id_ex && (hcu.rd_id_ex != '0) &&
                      ((hcu.uses_rs1_id && (hcu.rd_id_ex == hcu.rs1_if_id)) ||
                       (hcu.uses_rs2_id && (hcu.rd_id_ex == hcu.rs2_if_id)));

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (state_q == StStart) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (freeze) begin
            // EX is held, so a pending branch is acted on once the freeze releases.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            stall_inc   = 1'b1;
        end else if (hcu.branch_taken_ex) begin
            // The load-use victim in ID is on the wrong path and is flushed anyway.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStart:   state_d = StRun;
            StRun:     if (hcu.dmem_req && !hcu.dmem_ready) state_d = StMemWait;
            StMemWait: if (hcu.dmem_ready) state_d = StRun;
            default:   state_d = StStart;
        endcase
    end

    assign wait_clr = (state_q == StRun) && (state_d == StMemWait);
    assign wait_inc = (state_q == StMemWait);

    assign mem_timeout_d = mem_timeout_q ||
                           ((state_q == StMemWait) && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StStart;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .count (wait_cnt)
    );

    sat_counter #(.WIDTH(COUNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (1'b0),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(COUNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (1'b0),
        .count (flush_count)
    );

    assign hcu.pc_write    = pc_write;
    assign hcu.if_id_write = if_id_write;
    assign hcu.if_id_flush = if_id_flush;
    assign hcu.id_ex_flush = id_ex_flush;
    assign hcu.pipe_hold   = pipe_hold;
    assign hcu.mem_timeout = mem_timeout_q;
    assign hcu.stall_count = stall_count;
    assign hcu.flush_count = flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (32-bit and 4-bit counters) share one
// stimulus stream; a cycle-level behavioural model predicts every output.
module tb_hazard_control_unit;

    localparam int unsigned TIMEOUT = 255;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, req, rdy;

    hazard_control_unit_if #(.COUNT_W(32)) bus_a ();
    hazard_control_unit_if #(.COUNT_W(4))  bus_b ();

    assign bus_a.rs1_if_id = rs1;  assign bus_b.rs1_if_id = rs1;
    assign bus_a.rs2_if_id = rs2;  assign bus_b.rs2_if_id = rs2;
    assign bus_a.uses_rs1_id = u1; assign bus_b.uses_rs1_id = u1;
    assign bus_a.uses_rs2_id = u2; assign bus_b.uses_rs2_id = u2;
    assign bus_a.rd_id_ex = rd;    assign bus_b.rd_id_ex = rd;
    assign bus_a.mem_read_id_ex = mr;  assign bus_b.mem_read_id_ex = mr;
    assign bus_a.branch_taken_ex = br; assign bus_b.branch_taken_ex = br;
    assign bus_a.dmem_req = req;   assign bus_b.dmem_req = req;
    assign bus_a.dmem_ready = rdy; assign bus_b.dmem_ready = rdy;

    hazard_control_unit #(.COUNT_W(32), .WAIT_W(8), .TIMEOUT_CYCLES(TIMEOUT)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hcu   (bus_a)
    );

    hazard_control_unit #(.COUNT_W(4), .WAIT_W(8), .TIMEOUT_CYCLES(TIMEOUT)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hcu   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: purge cycle pending, memory wait in progress, cycles spent waiting so far.
    bit      m_purge, m_wait, m_timeout;
    int      m_waited;
    longint  m_stall, m_flush;
    bit      e_pc, e_ifw, e_iff, e_idf, e_hold, s_case, f_case;

    function automatic void model_reset();
        m_purge = 1; m_wait = 0; m_timeout = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    endfunction

    function automatic void eval();
        bit lu, fr;
        lu = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        fr = !m_purge && (m_wait ? !rdy : (req && !rdy));
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0; s_case = 0; f_case = 0;
        if (m_purge) begin
            e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
        end else if (fr) begin
            e_pc = 0; e_ifw = 0; e_hold = 1; s_case = 1;
        end else if (br) begin
            e_iff = 1; e_idf = 1; f_case = 1;
        end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_idf = 1; s_case = 1;
        end
    endfunction

    function automatic void model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        eval();
        if (m_purge) begin
            m_purge = 0;
        end else begin
            if (s_case) m_stall++;
            if (f_case) m_flush++;
            if (!m_wait) begin
                if (req && !rdy) begin
                    m_wait = 1;
                    m_waited = 0;
                end
            end else begin
                if (m_waited >= TIMEOUT) m_timeout = 1;
                m_waited++;
                if (rdy) m_wait = 0;
            end
        end
    endfunction

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (!rst_n) model_reset();
        eval();
        chk("pc_write",    32'(bus_a.pc_write),    32'(e_pc));
        chk("if_id_write", 32'(bus_a.if_id_write), 32'(e_ifw));
        chk("if_id_flush", 32'(bus_a.if_id_flush), 32'(e_iff));
        chk("id_ex_flush", 32'(bus_a.id_ex_flush), 32'(e_idf));
        chk("pipe_hold",   32'(bus_a.pipe_hold),   32'(e_hold));
        chk("mem_timeout", 32'(bus_a.mem_timeout), 32'(m_timeout));
        chk("stall_count", bus_a.stall_count, 32'(sat(m_stall, 64'hFFFF_FFFF)));
        chk("flush_count", bus_a.flush_count, 32'(sat(m_flush, 64'hFFFF_FFFF)));
        chk("stall_count_w4", 32'(bus_b.stall_count), 32'(sat(m_stall, 15)));
        chk("flush_count_w4", 32'(bus_b.flush_count), 32'(sat(m_flush, 15)));
        chk("pc_write_w4", 32'(bus_b.pc_write), 32'(e_pc));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; br = 0; req = 0; rdy = 0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst_n = 1'b0;

        // Reset held for three cycles, then the single purge cycle, then RUN.
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        cycle();

        // Load-use on rs2, then the same with rd = x0.
        rd = 5; mr = 1; rs2 = 5; u2 = 1;
        cycle();
        mr = 0;
        cycle();
        chk("lu_stall_count", bus_a.stall_count, 32'd1);
        rd = 0; mr = 1;
        cycle();

        // Branch and load-use together: branch wins.
        rd = 5; br = 1;
        cycle();
        br = 0; mr = 0;
        cycle();
        chk("br_flush_count", bus_a.flush_count, 32'd1);

        // Memory wait for 4 cycles with a branch held; flush only on release.
        req = 1; rdy = 0; br = 1;
        repeat (4) cycle();
        rdy = 1;
        cycle();
        req = 0; br = 0; rdy = 0;
        cycle();
        chk("wait_stall_count", bus_a.stall_count, 32'd5);

        // Same-cycle ready: no freeze.
        req = 1; rdy = 1;
        cycle();
        cycle();

        // Timeout: ready low for 256 cycles.
        req = 1; rdy = 0;
        repeat (256) cycle();
        rdy = 1;
        cycle();
        req = 0;
        repeat (3) cycle();
        chk("timeout_sticky", 32'(bus_a.mem_timeout), 32'd1);

        // Reset asserted mid-wait takes effect without a clock edge.
        req = 1; rdy = 0;
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc_write", 32'(bus_a.pc_write), 32'd0);
        chk("async_rst_timeout",  32'(bus_a.mem_timeout), 32'd0);
        cycle();
        idle_inputs();
        rst_n = 1'b1;
        cycle();

        // 20 load-use cycles: 4-bit counter pins at 15.
        rd = 7; mr = 1; rs1 = 7; u1 = 1;
        repeat (20) cycle();
        idle_inputs();
        cycle();
        chk("sat_stall_w4", 32'(bus_b.stall_count), 32'd15);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            u1  = 1'($urandom);
            u2  = 1'($urandom);
            mr  = 1'($urandom);
            br  = ($urandom_range(0, 4) == 0);
            req = 1'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
            rst_n = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
